// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared types and constants for the CP0 exception sequencer.
// Cause.ExcCode values, FSM state encoding, priority encoder.
package cp0_exc_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_COMMIT,
    S_REDIRECT,
    S_ERET
  } state_t;

  // Highest-priority pending cause; callers gate with "any request".
  function automatic logic [4:0] exc_sel(
    input logic int_ok,
    input logic adel,
    input logic ades,
    input logic sys,
    input logic ov
  );
    logic [4:0] c;
    c = EXC_OV;
    if (int_ok)    c = EXC_INT;
    else if (adel) c = EXC_ADEL;
    else if (ades) c = EXC_ADES;
    else if (sys)  c = EXC_SYS;
    else if (ov)   c = EXC_OV;
    return c;
  endfunction

  function automatic logic is_addr_code(input logic [4:0] c);
    return (c == EXC_ADEL) || (c == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_read_arb.sv
// Round-robin 2-way arbiter for the shared CP0 read port.
// Registered grants; blk suppresses any grant for the next cycle.
module cp0_read_arb
  import cp0_exc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_p,
  input  logic req_h,
  input  logic blk,
  output logic gnt_p,
  output logic gnt_h
);

  logic last_h;
  logic win_p;
  logic win_h;

  assign win_p = req_p & ~blk & (~req_h | last_h);
  assign win_h = req_h & ~blk & (~req_p | ~last_h);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_p  <= DISABLE;
      gnt_h  <= DISABLE;
      last_h <= ENABLE;
    end else begin
      gnt_p <= win_p;
      gnt_h <= win_h;
      if (win_p | win_h)
        last_h <= win_h;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception sequencer: IDLE->FLUSH->COMMIT->REDIRECT, or ERET.
// Define CP0_EXC_COUNT_EN to add the saturating exc_count output.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_int,
  input  logic        exc_adel,
  input  logic        exc_ades,
  input  logic        exc_sys,
  input  logic        exc_ov,
  input  logic        eret,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] pc_in,
  input  logic [31:0] bad_addr_in,
  input  logic [31:0] epc_val,
  input  logic        rd_req_p,
  input  logic        rd_req_h,
  output logic        stall,
  output logic        flush,
  output logic        we_epc,
  output logic        we_cause,
  output logic        set_exl,
  output logic        clr_exl,
  output logic        addr_err,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_out,
  output logic [31:0] badvaddr_out,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        r_p,
  output logic        r_h
`ifdef CP0_EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       exl_q;
  logic       int_ok;
  logic       any_exc;
  logic       to_commit;
  logic       blk_nxt;

  assign int_ok  = exc_int & status_ie & ~status_exl;
  assign any_exc = int_ok | exc_adel | exc_ades
                 | exc_sys | exc_ov;

  assign to_commit = (state == S_FLUSH) && (cnt == 4'd0);

  // Grants are registered, so block one cycle ahead of the write.
  assign blk_nxt = to_commit
                 | ((state == S_IDLE) & ~any_exc & eret);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      exl_q        <= DISABLE;
      stall        <= DISABLE;
      flush        <= DISABLE;
      we_epc       <= DISABLE;
      we_cause     <= DISABLE;
      set_exl      <= DISABLE;
      clr_exl      <= DISABLE;
      addr_err     <= DISABLE;
      redirect     <= DISABLE;
      exc_code     <= 5'd0;
      epc_out      <= 32'h0;
      badvaddr_out <= 32'h0;
      redirect_pc  <= 32'h0;
    end else begin
      we_epc      <= DISABLE;
      we_cause    <= DISABLE;
      set_exl     <= DISABLE;
      clr_exl     <= DISABLE;
      addr_err    <= DISABLE;
      redirect    <= DISABLE;
      redirect_pc <= 32'h0;
      unique case (state)
        S_IDLE: begin
          if (any_exc) begin
            state        <= S_FLUSH;
            cnt          <= CNT_LAST;
            exc_code     <= exc_sel(int_ok, exc_adel,
                                    exc_ades, exc_sys,
                                    exc_ov);
            epc_out      <= pc_in;
            badvaddr_out <= bad_addr_in;
            exl_q        <= status_exl;
            stall        <= ENABLE;
            flush        <= ENABLE;
          end else if (eret) begin
            state       <= S_ERET;
            clr_exl     <= ENABLE;
            redirect    <= ENABLE;
            redirect_pc <= epc_val;
            stall       <= ENABLE;
            flush       <= ENABLE;
          end else begin
            stall <= DISABLE;
            flush <= DISABLE;
          end
        end
        S_FLUSH: begin
          if (cnt == 4'd0) begin
            state    <= S_COMMIT;
            stall    <= ENABLE;
            flush    <= DISABLE;
            we_cause <= ENABLE;
            set_exl  <= ENABLE;
            we_epc   <= ~exl_q;
            addr_err <= is_addr_code(exc_code);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_COMMIT: begin
          state       <= S_REDIRECT;
          stall       <= ENABLE;
          flush       <= DISABLE;
          redirect    <= ENABLE;
          redirect_pc <= EXC_VECTOR;
        end
        S_REDIRECT, S_ERET: begin
          state <= S_IDLE;
          stall <= DISABLE;
          flush <= DISABLE;
        end
        default: begin
          state <= S_IDLE;
          stall <= DISABLE;
          flush <= DISABLE;
        end
      endcase
    end
  end

`ifdef CP0_EXC_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      exc_count <= 16'h0;
    else if (to_commit && exc_count != 16'hFFFF)
      exc_count <= exc_count + 16'd1;
  end
`endif

  cp0_read_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_p (rd_req_p),
    .req_h (rd_req_h),
    .blk   (blk_nxt),
    .gnt_p (r_p),
    .gnt_h (r_h)
  );

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed + randomized bench for cp0_exc_ctrl with a transaction model.
// Honours CP0_EXC_COUNT_EN when the design is built with it.
module tb_cp0_exc_ctrl;

  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'h0000_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_int, exc_adel, exc_ades, exc_sys, exc_ov;
  logic        eret, status_ie, status_exl;
  logic [31:0] pc_in, bad_addr_in, epc_val;
  logic        rd_req_p, rd_req_h;
  logic        stall, flush, we_epc, we_cause, set_exl, clr_exl;
  logic        addr_err, redirect, r_p, r_h;
  logic [4:0]  exc_code;
  logic [31:0] epc_out, badvaddr_out, redirect_pc;
`ifdef CP0_EXC_COUNT_EN
  logic [15:0] exc_count;
  int          m_count;
`endif

  int ncmp  = 0;
  int nfail = 0;
  bit m_last_h;
  bit rnd_rd;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .exc_int(exc_int), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_sys(exc_sys), .exc_ov(exc_ov), .eret(eret),
    .status_ie(status_ie), .status_exl(status_exl),
    .pc_in(pc_in), .bad_addr_in(bad_addr_in), .epc_val(epc_val),
    .rd_req_p(rd_req_p), .rd_req_h(rd_req_h),
    .stall(stall), .flush(flush), .we_epc(we_epc),
    .we_cause(we_cause), .set_exl(set_exl), .clr_exl(clr_exl),
    .addr_err(addr_err), .exc_code(exc_code), .epc_out(epc_out),
    .badvaddr_out(badvaddr_out), .redirect(redirect),
    .redirect_pc(redirect_pc), .r_p(r_p), .r_h(r_h)
`ifdef CP0_EXC_COUNT_EN
    , .exc_count(exc_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; blk says the cycle after this edge is a CP0 write cycle.
  task automatic step(input bit blk);
    bit ep, eh;
    if (rnd_rd) begin
      rd_req_p = 1'($urandom_range(0, 1));
      rd_req_h = 1'($urandom_range(0, 1));
    end
    ep = 0;
    eh = 0;
    if (!blk) begin
      if (rd_req_p && rd_req_h) begin
        ep = m_last_h;
        eh = !m_last_h;
      end else begin
        ep = rd_req_p;
        eh = rd_req_h;
      end
    end
    if (ep || eh) m_last_h = eh;
    @(posedge clk);
    #1;
    chk("r_p", r_p, ep);
    chk("r_h", r_h, eh);
  endtask

  task automatic clr_exc();
    exc_int = 0; exc_adel = 0; exc_ades = 0;
    exc_sys = 0; exc_ov = 0; eret = 0;
  endtask

  // Drive one request cycle and follow the whole resulting sequence.
  task automatic txn(input bit i, input bit al, input bit as,
                     input bit sy, input bit ov, input bit er,
                     input bit ie, input bit exl,
                     input logic [31:0] pc, input logic [31:0] ba,
                     input logic [31:0] ev);
    bit req[5];
    int codes[5];
    bit found;
    int code;
    req = '{i & ie & ~exl, al, as, sy, ov};
    codes = '{0, 4, 5, 8, 12};
    found = 0;
    code = 0;
    for (int k = 4; k >= 0; k--)
      if (req[k]) begin found = 1; code = codes[k]; end
    exc_int = i; exc_adel = al; exc_ades = as;
    exc_sys = sy; exc_ov = ov; eret = er;
    status_ie = ie; status_exl = exl;
    pc_in = pc; bad_addr_in = ba; epc_val = ev;
    if (found) begin
      step(0);
      clr_exc();
      chk("flush_stall", stall, 1);
      chk("flush_flush", flush, 1);
      chk("flush_wec", we_cause, 0);
      for (int k = 1; k < FC; k++) begin
        step(0);
        chk("flush_n", flush, 1);
        chk("flush_we", we_cause, 0);
      end
      step(1);
      chk("cm_stall", stall, 1);
      chk("cm_flush", flush, 0);
      chk("cm_we_cause", we_cause, 1);
      chk("cm_set_exl", set_exl, 1);
      chk("cm_we_epc", we_epc, !exl);
      chk("cm_addr_err", addr_err, (code == 4 || code == 5));
      chk("cm_code", exc_code, code);
      chk("cm_epc", epc_out, pc);
      chk("cm_bad", badvaddr_out, ba);
      chk("cm_clr_exl", clr_exl, 0);
      chk("cm_redirect", redirect, 0);
`ifdef CP0_EXC_COUNT_EN
      if (m_count < 16'hFFFF) m_count++;
      chk("exc_count", exc_count, m_count);
`endif
      step(0);
      chk("rd_redirect", redirect, 1);
      chk("rd_pc", redirect_pc, VEC);
      chk("rd_stall", stall, 1);
      chk("rd_we_cause", we_cause, 0);
      step(0);
      chk("post_stall", stall, 0);
      chk("post_redir", redirect, 0);
    end else if (er) begin
      step(1);
      clr_exc();
      chk("er_clr_exl", clr_exl, 1);
      chk("er_redirect", redirect, 1);
      chk("er_pc", redirect_pc, ev);
      chk("er_flush", flush, 1);
      chk("er_stall", stall, 1);
      chk("er_we_cause", we_cause, 0);
      step(0);
      chk("er_post", stall, 0);
      chk("er_post_clr", clr_exl, 0);
    end else begin
      step(0);
      clr_exc();
      chk("idle_stall", stall, 0);
      chk("idle_redir", redirect, 0);
    end
  endtask

  initial begin
    rst = 0;
    clr_exc();
    status_ie = 0; status_exl = 0;
    pc_in = 0; bad_addr_in = 0; epc_val = 0;
    rd_req_p = 0; rd_req_h = 0;
    rnd_rd = 0;
    m_last_h = 1;
`ifdef CP0_EXC_COUNT_EN
    m_count = 0;
`endif
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_code", exc_code, 0);
    chk("rst_epc", epc_out, 0);
    chk("rst_pc", redirect_pc, 0);
    #11 rst = 1;

    txn(0, 1, 0, 0, 0, 0, 1, 0, 32'h0040_0010, 32'h0000_1003, 0);
    txn(1, 0, 0, 0, 1, 0, 1, 0, 32'h0040_0100, 32'h0, 0);
    txn(1, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0104, 32'h0, 0);
    txn(0, 0, 0, 1, 0, 0, 1, 1, 32'h0040_0200, 32'h0, 0);
    txn(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h0040_0020);
    txn(0, 0, 0, 0, 1, 1, 1, 0, 32'h0040_0300, 0, 32'h0040_0020);

    rd_req_p = 1; rd_req_h = 0;
    step(0);
    rd_req_h = 1;
    step(0); chk("rr_h1", r_h, 1);
    step(0); chk("rr_p1", r_p, 1);
    step(0); chk("rr_h2", r_h, 1);
    step(0); chk("rr_p2", r_p, 1);
    txn(0, 0, 1, 0, 0, 0, 1, 0, 32'h0040_0400, 32'h0000_2002, 0);
    rd_req_p = 0; rd_req_h = 0;

    txn(0, 1, 0, 0, 0, 0, 1, 0, 32'h0040_0500, 32'h0000_3001, 0);
    step(0);
    rst = 0;
    #1;
    chk("mid_stall", stall, 0);
    chk("mid_flush", flush, 0);
    chk("mid_code", exc_code, 0);
    chk("mid_bad", badvaddr_out, 0);
    m_last_h = 1;
`ifdef CP0_EXC_COUNT_EN
    m_count = 0;
    chk("mid_count", exc_count, 0);
`endif
    #2 rst = 1;
    for (int k = 0; k < FC + 3; k++) begin
      step(0);
      chk("mid_we_cause", we_cause, 0);
      chk("mid_stall2", stall, 0);
    end

    rnd_rd = 1;
    for (int n = 0; n < 80; n++) begin
      bit [5:0] r;
      r = 6'($urandom) & 6'($urandom);
      txn(r[0], r[1], r[2], r[3], r[4], r[5],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom);
    end
    rnd_rd = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
